// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding and ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'h0;  // a + b
  localparam logic [3:0] ALU_SUB   = 4'h1;  // a - b
  localparam logic [3:0] ALU_AND   = 4'h2;  // a & b
  localparam logic [3:0] ALU_OR    = 4'h3;  // a | b
  localparam logic [3:0] ALU_XOR   = 4'h4;  // a ^ b
  localparam logic [3:0] ALU_NOR   = 4'h5;  // ~(a | b)
  localparam logic [3:0] ALU_NAND  = 4'h6;  // ~(a & b)
  localparam logic [3:0] ALU_XNOR  = 4'h7;  // ~(a ^ b)
  localparam logic [3:0] ALU_SLL   = 4'h8;  // a << b
  localparam logic [3:0] ALU_SRL   = 4'h9;  // a >> b (logical)
  localparam logic [3:0] ALU_SRA   = 4'hA;  // a >>> b (arithmetic)
  localparam logic [3:0] ALU_SLT   = 4'hB;  // signed a < b
  localparam logic [3:0] ALU_SLTU  = 4'hC;  // unsigned a < b
  localparam logic [3:0] ALU_PASSA = 4'hD;  // a
  localparam logic [3:0] ALU_PASSB = 4'hE;  // b
  localparam logic [3:0] ALU_NOTA  = 4'hF;  // ~a

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational N-bit ALU shared by all arbiter requesters.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   select,
  output logic [N-1:0] result
);

  // Operation decode; shift amounts of N or more saturate naturally.
  always_comb begin
    result = {N{1'b0}};
    case (select)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_NAND:  result = ~(a & b);
      ALU_XNOR:  result = ~(a ^ b);
      ALU_SLL:   result = a << b;
      ALU_SRL:   result = a >> b;
      ALU_SRA:   result = $signed(a) >>> b;
      ALU_SLT:   result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(N-1){1'b0}}, (a < b)};
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      ALU_NOTA:  result = ~a;
      default:   result = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting R requesters access to one shared ALU.
// Each grant runs IDLE -> EXEC -> RESP; the response is held until the
// granted requester accepts it, so grants are at least three cycles apart.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R*4-1:0] req_op,
  output logic [R-1:0]   rsp_valid,
  input  logic [R-1:0]   rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic           busy,
  output logic [15:0]    op_count
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] winner_q, winner_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic [R-1:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0]   op_count_q, op_count_d;

  logic [IW-1:0] pick_s;
  logic [IW-1:0] pick_next_s;
  logic [N-1:0]  alu_result_s;

  // First requester with valid set, scanning upward from ptr with wrap.
  function automatic logic [IW-1:0] rr_pick(input logic [R-1:0] valid,
                                            input logic [IW-1:0] ptr);
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < R; i++) begin
      int idx;
      idx = (int'(ptr) + i) % R;
      if (!found && valid[idx]) begin
        found   = 1'b1;
        rr_pick = IW'(idx);
      end
    end
  endfunction

  // Winner search and the pointer value that follows it.
  always_comb begin
    pick_s      = rr_pick(req_valid, rr_ptr_q);
    pick_next_s = (pick_s == IW'(R - 1)) ? {IW{1'b0}} : pick_s + IW'(1);
  end

  alu #(.N(N)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .select (op_q),
    .result (alu_result_s)
  );

  // Next-state, datapath capture and combinational grant.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = {R{1'b0}};
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[pick_s] = 1'b1;
          winner_d          = pick_s;
          a_d               = req_a[pick_s*N +: N];
          b_d               = req_b[pick_s*N +: N];
          op_d              = req_op[pick_s*4 +: 4];
          rr_ptr_d          = pick_next_s;
          state_d           = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d            = alu_result_s;
        rsp_valid_d           = {R{1'b0}};
        rsp_valid_d[winner_q] = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        // Only the winner's accept matters; other rsp_ready bits are ignored.
        if (rsp_ready[winner_q]) begin
          rsp_valid_d = {R{1'b0}};
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = {R{1'b0}};
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IW{1'b0}};
      winner_q    <= {IW{1'b0}};
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      op_q        <= 4'h0;
      rsp_data_q  <= {N{1'b0}};
      rsp_valid_q <= {R{1'b0}};
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic          clk;
  logic          rst_n;
  logic [R-1:0]  req_valid;
  logic [R-1:0]  req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R*4-1:0] req_op;
  logic [R-1:0]  rsp_valid;
  logic [R-1:0]  rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          busy;
  logic [15:0]   op_count;

  alu_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one in-flight transaction, age counted in cycles.
  bit busy_m;
  int age_m;     // 1 = cycle after grant, 2+ = response visible
  int win_m;
  int res_m;
  int ptr_m;
  int cnt_m;
  int data_m;
  int cyc;

  // Observed values from the most recent cycle.
  logic [3:0]  obs_rr;
  logic [3:0]  obs_rv;
  logic [7:0]  obs_data;
  logic        obs_busy;
  logic [15:0] obs_cnt;
  int g_idx[$];
  int g_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int alu_m(int a, int b, int op);
    int sa;
    int sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return 255 - (a | b);
      6:  return 255 - (a & b);
      7:  return 255 - (a ^ b);
      8:  return (b >= 8) ? 0 : (a * (1 << b)) % 256;
      9:  return (b >= 8) ? 0 : a / (1 << b);
      10: return (sa >>> ((b >= 8) ? 7 : b)) & 255;
      11: return (sa < sb) ? 1 : 0;
      12: return (a < b) ? 1 : 0;
      13: return a;
      14: return b;
      15: return 255 - a;
      default: return 0;
    endcase
  endfunction

  function automatic int pick_m(logic [3:0] v);
    for (int k = 0; k < R; k++) begin
      if (v[(ptr_m + k) % R]) return (ptr_m + k) % R;
    end
    return -1;
  endfunction

  task automatic model_reset();
    busy_m = 1'b0;
    age_m  = 0;
    win_m  = 0;
    res_m  = 0;
    ptr_m  = 0;
    cnt_m  = 0;
    data_m = 0;
  endtask

  task automatic check_outputs();
    int w;
    logic [3:0] e_rr;
    logic [3:0] e_rv;
    e_rr = 4'b0000;
    e_rv = 4'b0000;
    if (!busy_m) begin
      w = pick_m(req_valid);
      if (w >= 0) e_rr[w] = 1'b1;
    end
    if (busy_m && age_m >= 2) e_rv[win_m] = 1'b1;
    chk("req_ready", req_ready, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, data_m);
    chk("busy", busy, busy_m);
    chk("op_count", op_count, cnt_m);
    obs_rr   = req_ready;
    obs_rv   = rsp_valid;
    obs_data = rsp_data;
    obs_busy = busy;
    obs_cnt  = op_count;
    for (int k = 0; k < R; k++) begin
      if (req_ready[k]) begin
        g_idx.push_back(k);
        g_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic model_step();
    int w;
    if (!busy_m) begin
      w = pick_m(req_valid);
      if (w >= 0) begin
        busy_m = 1'b1;
        age_m  = 1;
        win_m  = w;
        res_m  = alu_m(int'(req_a[w*8 +: 8]), int'(req_b[w*8 +: 8]), int'(req_op[w*4 +: 4]));
        ptr_m  = (w + 1) % R;
      end
    end else if (age_m == 1) begin
      age_m  = 2;
      data_m = res_m;
    end else if (rsp_ready[win_m]) begin
      busy_m = 1'b0;
      cnt_m  = (cnt_m + 1) % 65536;
    end
  endtask

  task automatic cycle(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] op, input logic [3:0] rr);
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = rr;
    #1;
    check_outputs();
    model_step();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_rsp_data", rsp_data, 8'd0);
    chk("rst_req_ready", req_ready, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    logic [7:0]  held;
    logic [15:0] cnt0;
    logic [31:0] ra;
    logic [31:0] rb;
    int a8;
    int b8;

    exp_order = '{0, 1, 2, 3, 0};
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_op    = 16'h0;
    rsp_ready = 4'b0000;
    model_reset();
    do_reset();

    // Single request from requester 2: 5 + 3.
    cycle(4'b0100, 32'h0005_0000, 32'h0003_0000, 16'h0000, 4'hF);
    chk("t1_grant", obs_rr, 4'b0100);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t1_exec_no_valid", obs_rv, 4'b0000);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t1_rsp_valid", obs_rv, 4'b0100);
    chk("t1_rsp_data", obs_data, 8'd8);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t1_op_count", obs_cnt, 16'd1);
    chk("t1_idle", obs_busy, 1'b0);

    // All four requesting continuously: round-robin order and spacing.
    do_reset();
    g_idx.delete();
    g_cyc.delete();
    ra = $urandom;
    rb = $urandom;
    for (int i = 0; i < 15; i++) cycle(4'b1111, ra, rb, 16'h3210, 4'hF);
    chk("t2_ngrants", g_idx.size(), 5);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) chk("t2_order", g_idx[k], exp_order[k]);
    for (int k = 1; k < 5 && k < g_cyc.size(); k++) chk("t2_spacing", g_cyc[k] - g_cyc[k-1], 3);

    // Backpressure on requester 1 while requester 0 waits.
    cycle(4'b0011, $urandom, $urandom, 16'h0000, 4'hF);
    chk("t3_grant1", obs_rr, 4'b0010);
    cycle(4'b0001, $urandom, $urandom, 16'h0000, 4'b1101);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, $urandom, $urandom, 16'h0000, 4'b1101);
      if (i == 0) held = obs_data;
      chk("t3_rsp_held", obs_rv, 4'b0010);
      chk("t3_no_grant", obs_rr, 4'b0000);
      chk("t3_data_stable", obs_data, held);
    end
    cycle(4'b0001, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t3_release", obs_rv, 4'b0010);
    cycle(4'b0001, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t3_grant0", obs_rr, 4'b0001);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);

    // Wrong-port ready must not complete requester 3's response.
    cycle(4'b1000, $urandom, $urandom, 16'h4444, 4'b0001);
    chk("t4_grant3", obs_rr, 4'b1000);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'b0001);
    cnt0 = obs_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'b0001);
      chk("t4_rsp_valid", obs_rv, 4'b1000);
      chk("t4_busy", obs_busy, 1'b1);
      chk("t4_count", obs_cnt, cnt0);
    end
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'b1000);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t4_count_done", obs_cnt, cnt0 + 16'd1);

    // Reset while a response is pending, then search restarts at 0.
    cycle(4'b1000, $urandom, $urandom, 16'h7777, 4'b0000);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'b0000);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'b0000);
    chk("t5_in_resp", obs_rv, 4'b1000);
    do_reset();
    cycle(4'b1001, $urandom, $urandom, 16'h0000, 4'hF);
    chk("t5_grant0", obs_rr, 4'b0001);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);

    // Opcode sweep through requester 0.
    do_reset();
    for (int op = 0; op < 16; op++) begin
      a8 = $urandom_range(0, 255);
      b8 = (op >= 8 && op <= 10) ? $urandom_range(0, 9) : $urandom_range(0, 255);
      cycle(4'b0001, 32'(a8), 32'(b8), 16'(op), 4'hF);
      cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
      cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
      chk("t6_sweep_data", obs_data, alu_m(a8, b8, op));
    end
    cycle(4'b0000, 32'h0, 32'h0, 16'h0, 4'hF);
    chk("t6_op_count", obs_cnt, 16'd16);

    // Random traffic, including operands changing after grant.
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), $urandom, $urandom, 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 8, datapath width of shared ALU operands and result.
REQ-002 Parameter R, default 4, number of requesters sharing the ALU.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  R  per-requester operation request.
REQ-006 req_ready  output  R  per-requester accept, one-hot or zero.
REQ-007 req_a  input  R*N  packed operand A, requester i at bits [i*N +: N].
REQ-008 req_b  input  R*N  packed operand B, same packing.
REQ-009 req_op  input  R*4  packed 4-bit ALU select, requester i at bits [i*4 +: 4].
REQ-010 rsp_valid  output  R  per-requester result valid, one-hot or zero.
REQ-011 rsp_ready  input  R  per-requester result accept.
REQ-012 rsp_data  output  N  registered ALU result for the requester flagged in rsp_valid.
REQ-013 busy  output  1  high whenever FSM not in IDLE.
REQ-014 op_count  output  16  count of completed responses.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 In IDLE, if any req_valid high, winner = first set bit scanning upward from rr_ptr with wrap; req_ready[winner] high combinationally that cycle; all other req_ready low.
REQ-017 req_ready SHALL be zero in EXEC and RESP.
REQ-018 On the IDLE cycle with a grant, SHALL latch winner's a, b, op and winner index, advance rr_ptr to (winner+1) mod R, go to EXEC.
REQ-019 In EXEC, latched operands SHALL drive the ALU; ALU result SHALL be registered into rsp_data; go to RESP.
REQ-020 In RESP, rsp_valid[winner] SHALL be high, rsp_data stable; on rsp_ready[winner] high: increment op_count (wraps 16'hFFFF->0), go to IDLE.
REQ-021 Latency: grant at cycle T -> rsp_valid at T+2; minimum spacing between grants 3 cycles.
REQ-022 rsp_ready bits of non-selected requesters SHALL be ignored.
REQ-023 rsp_ready held low SHALL stall in RESP indefinitely; no new grants while stalled.
REQ-024 Request inputs changing after grant SHALL not affect the in-flight operation.
REQ-025 No req_valid in IDLE: stay IDLE, rr_ptr unchanged.
REQ-026 Requester protocol: req_valid, operands held until req_ready; arbiter correctness SHALL not depend on it beyond the grant cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, rr_ptr 0, rsp_data 0, latched operands 0, op_count 0, rsp_valid 0, busy 0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response and no count.
REQ-029 First grant after reset release SHALL start search at requester 0.

Structure
REQ-030 Shared package SHALL hold FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and ALU opcode constants incl. ALU_ADD=4'h0.
REQ-031 One sub-module SHALL be instantiated: the existing alu (parameter N; ports a, b, select, result), unmodified.
REQ-032 Round-robin winner selection SHALL be a function or block inside alu_arbiter, not a separate module.

Verification
REQ-033 Single request: req 2 valid, a=8'd5, b=8'd3, op=ALU_ADD, rsp_ready tied high -> req_ready[2] at T, rsp_valid=4'b0100 at T+2, rsp_data=8'd8, op_count=1.
REQ-034 All four valid continuously, rsp_ready high -> grant order 0,1,2,3,0; grants every 3 cycles; each rsp_data equals alu output for that requester's operands.
REQ-035 Backpressure: req 1 granted, rsp_ready[1] low 5 cycles with req 0 valid -> rsp_valid[1] held, rsp_data stable, req_ready all zero until rsp_ready[1] high; req 0 granted next IDLE cycle.
REQ-036 Wrong-port ready: rsp_valid[3] high, rsp_ready=4'b0001 -> stays RESP, op_count unchanged.
REQ-037 Reset mid-RESP: rst_n low asynchronously -> busy, rsp_valid, op_count, rsp_data 0 immediately; after release req 3 and req 0 valid -> req 0 granted first.
REQ-038 Sweep: 16 ops via requester 0 with op 0..15, random a/b -> every rsp_data matches alu output; op_count=16.
